// File: rtl/seq_mult16.sv
// seq_mult16: iterative unsigned shift-add multiplier.
// Takes WIDTH RUN cycles per operation and returns the full 2*WIDTH-bit
// product, a saturated WIDTH-bit product and an overflow flag.
// Valid/ready handshakes on both sides; only one operation is in flight.
module seq_mult16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     product_sat,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_mplier;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [2*WIDTH-1:0]   r_product;
  logic [WIDTH-1:0]     r_product_sat;
  logic                 r_overflow;

  logic [2*WIDTH-1:0]   w_acc_next;
  logic                 w_last;
  logic                 w_ovf_next;
  logic [WIDTH-1:0]     w_sat_next;

  // Next accumulator value for the current iteration and result decode
  always_comb begin
    w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    w_ovf_next = |w_acc_next[2*WIDTH-1:WIDTH];
    w_sat_next = w_ovf_next ? '1 : w_acc_next[WIDTH-1:0];
  end

  // Control FSM, datapath iteration and registered handshake/result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_mcand       <= '0;
      r_acc         <= '0;
      r_mplier      <= '0;
      r_cnt         <= '0;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_product     <= '0;
      r_product_sat <= '0;
      r_overflow    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_mcand    <= {{WIDTH{1'b0}}, a};
            r_mplier   <= b;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          // Result registers load on the final iteration so they are
          // already valid in the first DONE cycle.
          if (w_last) begin
            r_state       <= DONE;
            r_out_valid   <= 1'b1;
            r_product     <= w_acc_next;
            r_product_sat <= w_sat_next;
            r_overflow    <= w_ovf_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign product     = r_product;
  assign product_sat = r_product_sat;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_seq_mult16.sv
// Self-checking bench for seq_mult16: table-driven operations plus
// backpressure, reset-abort and back-to-back sequences, with a scoreboard
// queue filled at the input handshake and drained at the output handshake.
module tb_seq_mult16;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic [W-1:0]   product_sat;
  logic           overflow;

  seq_mult16 #(.WIDTH(W), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product),
    .product_sat (product_sat),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    logic [W-1:0]   sat;
    logic           ovf;
  } vec_t;

  typedef struct {
    logic [2*W-1:0] p;
    logic [W-1:0]   sat;
    logic           ovf;
    int             hs_cyc;
  } exp_t;

  exp_t sb[$];
  int   rises[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   last_rise = 0;
  logic prev_valid = 1'b0;

  // Cycle index as seen at the falling edge: number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one operation; returns one cycle after the accepting edge
  task automatic start_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [2*W-1:0] ep, input logic [W-1:0] es,
                          input logic eo, input bit keep_valid);
    exp_t e;
    bit   got;
    got      = 1'b0;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.p      = ep;
        e.sat    = es;
        e.ovf    = eo;
        e.hs_cyc = cyc;
        sb.push_back(e);
        got = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!got) check("accept_timeout", {63'd0, in_ready}, 64'd1);
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      check("result_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{a: 16'h0003, b: 16'h0005, p: 32'h0000000F, sat: 16'h000F, ovf: 1'b0};
    vecs[1] = '{a: 16'hFFFF, b: 16'hFFFF, p: 32'hFFFE0001, sat: 16'hFFFF, ovf: 1'b1};
    vecs[2] = '{a: 16'h0100, b: 16'h0100, p: 32'h00010000, sat: 16'hFFFF, ovf: 1'b1};
    vecs[3] = '{a: 16'h00FF, b: 16'h0101, p: 32'h0000FFFF, sat: 16'hFFFF, ovf: 1'b0};
    vecs[4] = '{a: 16'h1234, b: 16'h0000, p: 32'h00000000, sat: 16'h0000, ovf: 1'b0};
    vecs[5] = '{a: 16'h0000, b: 16'hABCD, p: 32'h00000000, sat: 16'h0000, ovf: 1'b0};
    vecs[6] = '{a: 16'h0001, b: 16'hFFFF, p: 32'h0000FFFF, sat: 16'hFFFF, ovf: 1'b0};
    vecs[7] = '{a: 16'h0002, b: 16'h8000, p: 32'h00010000, sat: 16'hFFFF, ovf: 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;

    // Output-side monitor: latency, result values, spurious results
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (rst) begin
          prev_valid = 1'b0;
        end else begin
          if (out_valid && !prev_valid) begin
            last_rise = cyc;
            rises.push_back(cyc);
          end
          if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
              check("spurious_out_valid", {63'd0, out_valid}, 64'd0);
            end else begin
              e = sb.pop_front();
              check("product", 64'(product), 64'(e.p));
              check("product_sat", 64'(product_sat), 64'(e.sat));
              check("overflow", {63'd0, overflow}, {63'd0, e.ovf});
              check("latency", 64'(last_rise - e.hs_cyc), 64'd17);
            end
          end
          prev_valid = out_valid;
        end
      end
    join_none

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_product", 64'(product), 64'd0);
    check("rst_product_sat", 64'(product_sat), 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven operations with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].sat, vecs[i].ovf, 1'b0);
      wait_done();
      @(posedge clk);
      #1;
    end

    // Backpressure: result held 10 cycles, new operands refused meanwhile
    out_ready = 1'b0;
    start_op(16'h00AB, 16'h0100, 32'h0000AB00, 16'hAB00, 1'b0, 1'b0);
    for (int i = 0; i < 40 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    a        = 16'h0005;
    b        = 16'h0005;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_product", 64'(product), 64'h0000AB00);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_done();
    @(negedge clk);
    check("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (20) @(posedge clk);
    #1;

    // Reset abort during RUN; the aborted result must never appear
    start_op(16'h0007, 16'h0009, 32'h0000003F, 16'h003F, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_product", 64'(product), 64'd0);
    repeat (25) @(posedge clk);
    #1;
    start_op(16'h0002, 16'h0003, 32'h00000006, 16'h0006, 1'b0, 1'b0);
    wait_done();
    @(posedge clk);
    #1;

    // Back-to-back with in_valid and out_ready held high
    rises.delete();
    start_op(16'h0002, 16'h0003, 32'h00000006, 16'h0006, 1'b0, 1'b1);
    start_op(16'h0014, 16'h0014, 32'h00000190, 16'h0190, 1'b0, 1'b1);
    start_op(16'h0001, 16'h0001, 32'h00000001, 16'h0001, 1'b0, 1'b0);
    wait_done();
    check("b2b_result_count", 64'(rises.size()), 64'd3);
    if (rises.size() == 3) begin
      check("b2b_spacing_1", 64'(rises[1] - rises[0]), 64'd18);
      check("b2b_spacing_2", 64'(rises[2] - rises[1]), 64'd18);
    end

    repeat (5) @(posedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_mult16.md
Name: seq_mult16

Overview:
- Iterative unsigned shift-add multiplier that produces the operand stream for the 16-bit right-shift scaling stage. It sits directly upstream of that stage.
- Multiplies two WIDTH-bit unsigned operands over WIDTH cycles and emits the full 2*WIDTH-bit product.
- It also emits a saturated WIDTH-bit product and an overflow flag; the saturated value drives the shifter's data input.
- Valid/ready handshake on both sides, one operation in flight.

Parameters:
- WIDTH, 16, operand width in bits; product width is 2*WIDTH.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands a, b are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product outputs are valid.
- out_ready  input  1  downstream accepts the result.
- product  output  2*WIDTH  full product a*b.
- product_sat  output  WIDTH  product clamped to 2^WIDTH-1.
- overflow  output  1  product[2*WIDTH-1:WIDTH] != 0.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; it is sampled only on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, product=0, product_sat=0, overflow=0, counter=0, internal registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch mcand={WIDTH'b0,a}, mplier=b; clear acc; counter=0; go to RUN.
  - a and b are ignored in every state except IDLE.
- RUN, one iteration per cycle:
  - If mplier[0], acc += mcand (2*WIDTH-bit add, no carry-out possible).
  - Then mcand <<= 1, mplier >>= 1, counter++.
  - When counter==WIDTH-1 finishes its update, go to DONE.
  - Exactly WIDTH RUN cycles; no early termination when mplier hits zero.
- DONE:
  - out_valid=1; product=acc.
  - product_sat = overflow ? all-ones : acc[WIDTH-1:0].
  - Outputs stay stable while out_valid && !out_ready (backpressure holds indefinitely).
  - On out_ready: return to IDLE, out_valid=0 next cycle. Product registers retain their last value.
- Latency: handshake at cycle 0 -> out_valid asserted at cycle WIDTH+1 (17 for WIDTH=16).
  - Back-to-back throughput: one result per WIDTH+2 cycles, because in_ready is high only in IDLE.
- in_ready is a registered state decode. No combinational path from in_valid or out_ready to in_ready.
- Boundaries:
  - a=0 or b=0 -> product=0, overflow=0.
  - a=b=2^WIDTH-1 -> product=2^(2*WIDTH)-2^(WIDTH+1)+1, with no wrap.
  - Product exactly 2^WIDTH -> overflow=1, product_sat=all-ones.
  - Product exactly 2^WIDTH-1 -> overflow=0.
- Simultaneous events:
  - In DONE, in_valid is ignored while in_ready=0.
  - out_ready asserted while not in DONE has no effect.
- Reset mid-operation: rst in RUN or DONE aborts the operation and returns all registers to reset values on that edge; no result is emitted.

Test Plan:
- Reset, then a=0x0003, b=0x0005, in_valid pulse, out_ready=1 -> out_valid exactly 17 cycles after the handshake; product=0x0000000F, product_sat=0x000F, overflow=0.
- a=0xFFFF, b=0xFFFF -> product=0xFFFE0001, product_sat=0xFFFF, overflow=1.
- Overflow boundary:
  - a=0x0100, b=0x0100 -> product=0x00010000, overflow=1, product_sat=0xFFFF.
  - a=0x00FF, b=0x0101 -> product=0x0000FFFF, overflow=0, product_sat=0xFFFF.
- Zero and backpressure:
  - a=0x1234, b=0x0000 -> product=0.
  - Hold out_ready=0 for 10 cycles: out_valid and product stay stable, in_ready=0, and a new in_valid during this time is not accepted.
- Reset abort: start a=0x0007, b=0x0009, assert rst at RUN cycle 5 -> next cycle out_valid=0, in_ready=1. A subsequent a=0x0002, b=0x0003 yields product=0x00000006.
- Back-to-back: three operations with in_valid and out_ready held high -> results 6, 0x0190 (a=0x0014, b=0x0014), 1 (a=1, b=1), in order, spaced 18 cycles apart.
